uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Byte FIFO and drain engine upstream of the uart peripheral's transmit path.
- The CPU pushes bytes into the FIFO through a slave register port. An internal FSM drives a master port into the uart register map. It polls STATUS bit[0] (tx busy), writes TXDATA, then confirms acceptance before popping the byte.
- Removes per-byte busy polling from software. Sits on the peripheral bus beside the uart; its master port is muxed onto the uart's we/addr/data ports.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries of 8 bits).
- UART_BASE, 32'h3000_0000, base address placed on uart_addr_o; offsets STATUS = 0x4, TXDATA = 0xC are added to it.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  slave write strobe.
- addr_i  in  32  slave address; only [7:0] decoded.
- data_i  in  32  slave write data.
- data_o  out  32  slave read data; combinational from addr_i.
- uart_we_o  out  1  master write strobe to uart.
- uart_addr_o  out  32  master address to uart.
- uart_data_o  out  32  master write data to uart.
- uart_data_i  in  32  uart combinational read data for uart_addr_o.
- irq_o  out  1  level; high when CTRL.en = 1, FIFO empty and FSM in IDLE.

Behaviour:
- Slave register map:
  - 0x00 CTRL rw: bit0 en (drain enable); bit1 flush, write-1 self-clearing, always reads 0.
  - 0x04 STATUS ro: bit0 full; bit1 empty; [8+DEPTH_LOG2:8] count.
  - 0x08 TXDATA wo: push data_i[7:0].
  - 0x0C ERR: bit0 overflow, sticky, write-1-to-clear.
  - Unmapped addresses read 0.
- Reset (rst = 1 at posedge):
  - count, rd/wr pointers, CTRL and ERR all 0.
  - State = IDLE.
  - uart_we_o = 0, uart_addr_o = UART_BASE+0x4, uart_data_o = 0, irq_o = 0, data_o reflects reset registers.
- Push:
  - A write to TXDATA with count < DEPTH stores the byte at wr_ptr; wr_ptr and count increment.
  - Full is judged on count before this cycle's update. A push at count == DEPTH is dropped and sets ERR.overflow, even if a pop happens the same cycle.
  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; count has width DEPTH_LOG2+1.
- FSM master outputs decode combinationally from state; uart_we_o is high only in WRITE.
  - IDLE: addr = STATUS. Go to POLL if en && count != 0.
  - POLL: addr = STATUS, we = 0. If !en, go to IDLE. Else if uart_data_i[0] == 0, go to WRITE. Else stay.
  - WRITE: we = 1, addr = TXDATA, data = {24'h0, fifo[rd_ptr]}. Always go to CONFIRM.
  - CONFIRM: addr = STATUS. If uart_data_i[0] == 1, pop (rd_ptr++, count--) and go to IDLE. Else (write ignored, e.g. uart tx disabled) go to POLL and retry the same byte. No byte is lost.
- Latency: a push in cycle 0, with en = 1, FIFO previously empty and uart idle, gives uart_we_o = 1 in cycle 3 and the pop at the end of cycle 4.
- Back-to-back bytes: the FSM returns through IDLE → POLL and waits out uart busy.
- Clearing en: takes effect in IDLE/POLL only. A WRITE/CONFIRM in flight completes normally.
- Flush:
  - Clears count, both pointers and the FSM state to IDLE in the next cycle.
  - A byte already written by WRITE is not recalled from the uart.
  - A push in the same cycle as flush is discarded.
- Requirement on the uart: baud divisor ≥ 2, so its busy bit is still set in CONFIRM.
- Master port drives the uart only through uart_we_o for TXDATA. It never writes uart CTRL/BAUD; software enables the uart tx.

Decomposition:
- Shared package holds:
  - Slave offsets: CTRL, STATUS, TXDATA, ERR.
  - uart offsets: STATUS 0x4, TXDATA 0xC.
  - FSM state encodings: one-hot, 4 bits.
- One natural sub-module, sync_fifo_8b: parameterised storage, pointers and count with push/pop/flush, full/empty/count outputs. The FSM and register file stay in uart_tx_fifo.

Test Plan:
- Reset then read 0x04 → 0x0000_0002 (empty). irq_o = 0. uart_we_o stays 0 for 20 cycles.
- en = 1; push 0x41 with uart model idle → uart_we_o = 1 exactly 3 cycles later with uart_data_o = 0x41, uart_addr_o = UART_BASE+0xC; count returns to 0; irq_o rises.
- Push 0x32, 0x30, 0x32 with uart model busy for 100 cycles per byte → three writes in order, each only after busy falls; no write while busy = 1.
- en = 0; push 17 bytes → count = 16, full = 1, ERR = 1. Write 0x1 to ERR → ERR = 0. Enable → exactly 16 bytes drained in push order.
- uart model ignores TXDATA writes (tx disabled) → FSM retries the same byte repeatedly with count unchanged; after the model is enabled the byte is sent once.
- Flush with 5 queued bytes during POLL → count = 0 next cycle, state IDLE, no further uart_we_o. Assert rst mid-CONFIRM → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the uart transmit FIFO: slave register offsets,
// uart register offsets and the one-hot drain FSM encoding.
package uart_tx_fifo_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_TXDATA = 8'h08;
  localparam logic [7:0] REG_ERR    = 8'h0C;

  localparam logic [31:0] UART_STATUS_OFS = 32'h4;
  localparam logic [31:0] UART_TXDATA_OFS = 32'hC;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_POLL    = 4'b0010,
    ST_WRITE   = 4'b0100,
    ST_CONFIRM = 4'b1000
  } state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side register port plus the master port muxed onto the uart register map.
interface uart_tx_fifo_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        uart_we_o;
  logic [31:0] uart_addr_o;
  logic [31:0] uart_data_o;
  logic [31:0] uart_data_i;

  modport slave (
    input  we_i, addr_i, data_i, uart_data_i,
    output data_o, uart_we_o, uart_addr_o, uart_data_o
  );
  modport master (
    output we_i, addr_i, data_i, uart_data_i,
    input  data_o, uart_we_o, uart_addr_o, uart_data_o
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo_8b.sv
// Byte FIFO: storage, wrapping pointers and an occupancy count.
// Push when full and pop when empty are ignored; flush clears everything.
module sync_fifo_8b #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Register-mapped byte FIFO in front of the uart; an FSM drains it by polling
// uart busy, writing TXDATA and confirming acceptance before popping.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] UART_BASE  = 32'h3000_0000
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus,
  output logic           irq_o
);
  logic [7:0]            reg_a;
  logic                  wr_ctrl, wr_err, push_req, flush, pop;
  logic                  en_q, ovf_q;
  logic                  full, empty;
  logic [7:0]            fifo_dout;
  logic [DEPTH_LOG2:0]   count;
  state_e                state_q, state_d;

  assign reg_a    = bus.addr_i[7:0];
  assign wr_ctrl  = bus.we_i && (reg_a == REG_CTRL);
  assign wr_err   = bus.we_i && (reg_a == REG_ERR);
  assign push_req = bus.we_i && (reg_a == REG_TXDATA);
  assign flush    = wr_ctrl && bus.data_i[1];
  // Pop only once the uart reports busy after our write, i.e. it took the byte.
  assign pop      = (state_q == ST_CONFIRM) && bus.uart_data_i[0];

  sync_fifo_8b #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (bus.data_i[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ctrl) en_q <= bus.data_i[0];
      if (push_req && full)            ovf_q <= 1'b1;
      else if (wr_err && bus.data_i[0]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (en_q && !empty) state_d = ST_POLL;
      ST_POLL:    if (!en_q) state_d = ST_IDLE;
                  else if (!bus.uart_data_i[0]) state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_CONFIRM;
      ST_CONFIRM: state_d = bus.uart_data_i[0] ? ST_IDLE : ST_POLL;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.uart_we_o   = 1'b0;
    bus.uart_addr_o = UART_BASE + UART_STATUS_OFS;
    bus.uart_data_o = '0;
    if (state_q == ST_WRITE) begin
      bus.uart_we_o   = 1'b1;
      bus.uart_addr_o = UART_BASE + UART_TXDATA_OFS;
      bus.uart_data_o = {24'h0, fifo_dout};
    end
  end

  always_comb begin
    bus.data_o = '0;
    case (reg_a)
      REG_CTRL:   bus.data_o[0] = en_q;
      REG_STATUS: begin
        bus.data_o[0]                = full;
        bus.data_o[1]                = empty;
        bus.data_o[8 +: DEPTH_LOG2+1] = count;
      end
      REG_ERR:    bus.data_o[0] = ovf_q;
      default:    ;
    endcase
  end

  assign irq_o = en_q && empty && (state_q == ST_IDLE);
endmodule
